// File: rtl/coin_acceptor.sv
// Coin-sensor front end: synchronises, debounces and arbitrates nickel/dime pulses, and flags jams.
// Optional running total (port total / clear_total) enabled by defining COIN_ACCEPTOR_TOTAL_EN.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JAM_CYCLES      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sense_nickel,
  input  logic        sense_dime,
`ifdef COIN_ACCEPTOR_TOTAL_EN
  input  logic        clear_total,
  output logic [15:0] total,
`endif
  output logic        nickel,
  output logic        dime,
  output logic        jam,
  output logic        busy
);

  localparam int unsigned NCH       = 2;
  localparam int unsigned CH_NICKEL = 0;
  localparam int unsigned CH_DIME   = 1;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned JAM_W     = 16;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [JAM_W-1:0] JAM_LIMIT = JAM_W'(JAM_CYCLES);

  logic [NCH-1:0]            s1_q, s1_d;
  logic [NCH-1:0]            s2_q, s2_d;
  logic [NCH-1:0]            stable_q, stable_d;
  logic [NCH-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [NCH-1:0][JAM_W-1:0] jam_cnt_q, jam_cnt_d;
  logic [NCH-1:0]            jam_flag_q, jam_flag_d;
  logic [NCH-1:0]            raw_c;
  logic [NCH-1:0]            event_c;

  logic nickel_q, nickel_d;
  logic dime_q, dime_d;
  logic jam_q, jam_d;
  logic busy_q, busy_d;
  logic pend_n_q, pend_n_d;
  logic pend_d_q, pend_d_d;

`ifdef COIN_ACCEPTOR_TOTAL_EN
  localparam int unsigned TOT_W = 16;
  logic [TOT_W-1:0] total_q, total_d;
`endif

  always_comb begin
    raw_c      = {sense_dime, sense_nickel};
    s1_d       = raw_c;
    s2_d       = s1_q;
    stable_d   = stable_q;
    db_cnt_d   = '0;
    jam_cnt_d  = jam_cnt_q;
    jam_flag_d = '0;
    event_c    = '0;

    // Debounce and jam tracking per channel; an event is an accepted rising level.
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      if (s2_q[ch] != stable_q[ch]) begin
        if (db_cnt_q[ch] == DB_LAST) begin
          stable_d[ch] = s2_q[ch];
        end else begin
          db_cnt_d[ch] = db_cnt_q[ch] + CNT_W'(1);
        end
      end
      event_c[ch] = stable_d[ch] & ~stable_q[ch] & ~jam_flag_q[ch];

      if (!stable_d[ch]) begin
        jam_cnt_d[ch] = '0;
      end else if (stable_q[ch] && (jam_cnt_q[ch] < JAM_LIMIT)) begin
        jam_cnt_d[ch] = jam_cnt_q[ch] + JAM_W'(1);
      end
      jam_flag_d[ch] = stable_d[ch] & (jam_flag_q[ch] | (jam_cnt_d[ch] == JAM_LIMIT));
    end

    nickel_d = 1'b0;
    dime_d   = 1'b0;
    pend_n_d = 1'b0;
    pend_d_d = 1'b0;

    // Deferred coins go out before fresh events; simultaneous fresh events send the dime first.
    if (pend_n_q) begin
      nickel_d = 1'b1;
      pend_n_d = event_c[CH_NICKEL];
      pend_d_d = event_c[CH_DIME];
    end else if (pend_d_q) begin
      dime_d   = 1'b1;
      pend_n_d = event_c[CH_NICKEL];
      pend_d_d = event_c[CH_DIME];
    end else if (event_c[CH_DIME]) begin
      dime_d   = 1'b1;
      pend_n_d = event_c[CH_NICKEL];
    end else begin
      nickel_d = event_c[CH_NICKEL];
    end

    busy_d = pend_n_d;
    jam_d  = |jam_flag_d;

`ifdef COIN_ACCEPTOR_TOTAL_EN
    total_d = total_q;
    if (clear_total) begin
      total_d = '0;
    end else if (nickel_q) begin
      total_d = total_q + TOT_W'(5);
    end else if (dime_q) begin
      total_d = total_q + TOT_W'(10);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      db_cnt_q   <= '0;
      jam_cnt_q  <= '0;
      jam_flag_q <= '0;
      nickel_q   <= 1'b0;
      dime_q     <= 1'b0;
      jam_q      <= 1'b0;
      busy_q     <= 1'b0;
      pend_n_q   <= 1'b0;
      pend_d_q   <= 1'b0;
`ifdef COIN_ACCEPTOR_TOTAL_EN
      total_q    <= '0;
`endif
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      jam_cnt_q  <= jam_cnt_d;
      jam_flag_q <= jam_flag_d;
      nickel_q   <= nickel_d;
      dime_q     <= dime_d;
      jam_q      <= jam_d;
      busy_q     <= busy_d;
      pend_n_q   <= pend_n_d;
      pend_d_q   <= pend_d_d;
`ifdef COIN_ACCEPTOR_TOTAL_EN
      total_q    <= total_d;
`endif
    end
  end

  assign nickel = nickel_q;
  assign dime   = dime_q;
  assign jam    = jam_q;
  assign busy   = busy_q;
`ifdef COIN_ACCEPTOR_TOTAL_EN
  assign total  = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: a window-based reference model queues expected pulses/levels,
// and a negedge monitor pops and compares them against the DUT.
module tb_coin_acceptor;

  localparam int D = 4;
  localparam int J = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        sense_nickel;
  logic        sense_dime;
  logic        nickel;
  logic        dime;
  logic        jam;
  logic        busy;
`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic        clear_total;
  logic [15:0] total;
`endif

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
    .clk          (clk),
    .reset        (reset),
    .sense_nickel (sense_nickel),
    .sense_dime   (sense_dime),
`ifdef COIN_ACCEPTOR_TOTAL_EN
    .clear_total  (clear_total),
    .total        (total),
`endif
    .nickel       (nickel),
    .dime         (dime),
    .jam          (jam),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit is_dime;
  } pulse_t;

  typedef struct {
    int          cyc;
    bit          jam;
    bit          busy;
    logic [15:0] total;
  } level_t;

  pulse_t pq[$];
  level_t lq[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state: raw sample history, accepted level, high-time, output order queue.
  bit          mhist[2][$];
  bit          mstable[2];
  int          mhi[2];
  int          fifo[$];
  logic [15:0] mtotal;
  int          prev_amt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the last D samples seen through the two-stage
  // synchroniser all differ from it; accepted coins leave in arrival order, one per cycle.
  always @(posedge clk) begin
    bit     raw[2];
    bit     ev[2];
    bit     all_diff;
    bit     has_n;
    bit     jflag;
    int     idx;
    pulse_t p;
    level_t l;
    cyc++;
    raw[0] = sense_nickel;
    raw[1] = sense_dime;
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        mhist[ch].delete();
        repeat (D + 2) mhist[ch].push_back(1'b0);
        mstable[ch] = 1'b0;
        mhi[ch]     = 0;
      end
      fifo.delete();
      mtotal   = '0;
      prev_amt = 0;
      l.cyc = cyc; l.jam = 1'b0; l.busy = 1'b0; l.total = '0;
      lq.push_back(l);
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        mhist[ch].push_back(raw[ch]);
        if (mhist[ch].size() > D + 2) void'(mhist[ch].pop_front());
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) begin
          idx = mhist[ch].size() - 3 - i;
          if (mhist[ch][idx] == mstable[ch]) all_diff = 1'b0;
        end
        ev[ch] = 1'b0;
        if (all_diff) begin
          mstable[ch] = ~mstable[ch];
          ev[ch]      = mstable[ch];
          mhi[ch]     = 0;
        end else if (mstable[ch] && mhi[ch] < J) begin
          mhi[ch]++;
        end
      end
`ifdef COIN_ACCEPTOR_TOTAL_EN
      if (clear_total) mtotal = '0;
      else mtotal = mtotal + 16'(prev_amt);
`endif
      if (ev[1]) fifo.push_back(1);
      if (ev[0]) fifo.push_back(0);
      prev_amt = 0;
      if (fifo.size() > 0) begin
        p.cyc     = cyc;
        p.is_dime = (fifo.pop_front() == 1);
        pq.push_back(p);
        prev_amt  = p.is_dime ? 10 : 5;
      end
      has_n = 1'b0;
      foreach (fifo[i]) if (fifo[i] == 0) has_n = 1'b1;
      jflag = (mstable[0] && mhi[0] >= J) || (mstable[1] && mhi[1] >= J);
      l.cyc = cyc; l.jam = jflag; l.busy = has_n; l.total = mtotal;
      lq.push_back(l);
    end
  end

  // Monitor: compares levels every cycle and pops an expected pulse whenever the DUT pulses.
  always @(negedge clk) begin
    level_t l;
    pulse_t p;
    if (lq.size() > 0) begin
      l = lq.pop_front();
      check("jam", 16'(jam), 16'(l.jam));
      check("busy", 16'(busy), 16'(l.busy));
`ifdef COIN_ACCEPTOR_TOTAL_EN
      check("total", total, l.total);
`endif
    end
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      p = pq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse cycle %0d: got none expected %s", p.cyc, p.is_dime ? "dime" : "nickel");
    end
    if (nickel || dime) begin
      if (nickel && dime) begin
        check("both_high", 16'({nickel, dime}), 16'b01);
      end else if (pq.size() == 0 || pq[0].cyc != cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse cycle %0d: got nickel=%0b dime=%0b expected none", cyc, nickel, dime);
      end else begin
        p = pq.pop_front();
        check("pulse_is_dime", 16'(dime), 16'(p.is_dime));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int hold[2];
    bit lvl[2];
    reset        = 1'b1;
    sense_nickel = 1'b0;
    sense_dime   = 1'b0;
`ifdef COIN_ACCEPTOR_TOTAL_EN
    clear_total  = 1'b0;
`endif
    tick(3);
    reset = 1'b0;
    tick(5);

    // Single clean nickel.
    sense_nickel = 1'b1; tick(20);
    sense_nickel = 1'b0; tick(15);

    // Bouncing dime, then a steady press.
    for (int i = 0; i < 5; i++) begin
      sense_dime = 1'b1; tick(2);
      sense_dime = 1'b0; tick(2);
    end
    sense_dime = 1'b1; tick(15);
    sense_dime = 1'b0; tick(15);

    // Simultaneous coins: dime first, deferred nickel next cycle.
    sense_nickel = 1'b1; sense_dime = 1'b1; tick(10);
    sense_nickel = 1'b0; sense_dime = 1'b0; tick(15);

    // Jammed nickel sensor.
    sense_nickel = 1'b1; tick(100);
    sense_nickel = 1'b0; tick(20);

    // Reset lands while the deferred nickel is pending.
    sense_nickel = 1'b1; sense_dime = 1'b1; tick(6);
    reset = 1'b1; tick(2);
    reset = 1'b0; sense_nickel = 1'b0; sense_dime = 1'b0; tick(15);

`ifdef COIN_ACCEPTOR_TOTAL_EN
    for (int i = 0; i < 3; i++) begin
      sense_nickel = 1'b1; tick(8);
      sense_nickel = 1'b0; tick(12);
    end
    for (int i = 0; i < 2; i++) begin
      sense_dime = 1'b1; tick(8);
      sense_dime = 1'b0; tick(12);
    end
    tick(5);
    clear_total = 1'b1; tick(1);
    clear_total = 1'b0; tick(5);
`endif

    // Random bouncing with occasional long holds and rare resets.
    hold[0] = 0;
    hold[1] = 0;
    lvl[0]  = 1'b0;
    lvl[1]  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          lvl[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 90))
                                                 : int'($urandom_range(1, 10));
        end
        hold[ch]--;
      end
      sense_nickel = lvl[0];
      sense_dime   = lvl[1];
      reset        = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    reset        = 1'b0;
    sense_nickel = 1'b0;
    sense_dime   = 1'b0;
    tick(30);

    check("leftover_pulses", 16'(pq.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage that feeds the vending FSM.
- Synchronises and debounces the raw nickel and dime coin-sensor lines.
- Emits clean single-cycle nickel/dime pulses; never both in the same cycle.
- Flags a jammed sensor.
- Outputs connect directly to the FSM's nickel/dime inputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a sensor must hold a new level before it is accepted. Legal range 1..255.
- JAM_CYCLES, 64: cycles a debounced sensor may stay high before jam is flagged. Must be greater than DEBOUNCE_CYCLES; legal up to 65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sense_nickel  in  1  raw nickel sensor, asynchronous to clk, may bounce
- sense_dime  in  1  raw dime sensor, asynchronous to clk, may bounce
- nickel  out  1  one-cycle pulse per accepted nickel
- dime  out  1  one-cycle pulse per accepted dime
- jam  out  1  high while either channel is jammed
- busy  out  1  high while a deferred nickel is pending

Behaviour:
- Clock/reset: single clock domain; reset is synchronous and active-high.
- Reset values: nickel=0, dime=0, jam=0, busy=0. Synchroniser flops, stable levels, debounce counters, jam counters and pending flag all clear to 0.
- Reset asserted mid-operation:
  - Any in-flight or pending coin is discarded.
  - No pulse is emitted in the cycle after reset deasserts.
- Synchroniser: two-flop synchroniser per channel (s1, s2).
- Debounce, per channel:
  - The channel has a stable level and an 8-bit counter.
  - At each edge where s2 != stable: if counter == DEBOUNCE_CYCLES-1, stable <= s2 and counter <= 0; otherwise counter increments.
  - At each edge where s2 == stable: counter <= 0. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Event: an accepted 0->1 transition of stable.
  - Latency: raw input first sampled high at edge t0 and held; the event registers at edge t0+DEBOUNCE_CYCLES+1, so the pulse is high in the following cycle.
  - 1->0 transitions are debounced identically but produce no pulse.
- Output arbitration:
  - At most one of nickel/dime is high in any cycle; each pulse lasts exactly 1 cycle.
  - Dime event alone: dime pulses.
  - Nickel event alone with no pending nickel: nickel pulses.
  - Simultaneous nickel and dime events: dime pulses now; the nickel is deferred (pending=1, busy=1) and pulses in the next cycle, after which pending clears.
  - Pending nickel while a new dime event arrives: the pending nickel goes first and the dime is deferred one cycle.
  - At most one deferral per channel is needed: debounce guarantees at least 2*DEBOUNCE_CYCLES cycles between events on the same channel.
- Jam, per channel:
  - A 16-bit counter increments while stable==1 and saturates at JAM_CYCLES.
  - When it reaches JAM_CYCLES the channel's jam flag sets.
  - The flag and counter clear when stable returns to 0.
  - jam = OR of both channel flags.
  - A jammed channel produces no further events until released; any event already emitted stands.

Optional Feature:
- Macro: COIN_ACCEPTOR_TOTAL_EN
- Defined:
  - Adds output port total, 16 bits, reset 0.
  - total increments by 5 in the cycle nickel is high and by 10 in the cycle dime is high.
  - Wraps modulo 65536 with no saturation.
  - Adds input clear_total (1 bit): zeroes total at the next edge. If a pulse occurs in the same cycle, clear wins.
- Not defined: neither port exists; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, JAM_CYCLES=64):
- Reset, then sense_nickel held high from edge 10 -> nickel=1 only in the cycle after edge 15; dime never high; jam=0.
- sense_dime toggles high/low every 2 cycles for 20 cycles, then stays high -> no dime pulse during toggling; exactly one dime pulse 5 edges after the final rise.
- sense_nickel and sense_dime rise on the same edge and are held 10 cycles -> dime pulses at the cycle after edge t0+5 and nickel the cycle after; busy=1 only in the dime cycle; never both high together.
- sense_nickel held high for 100 cycles -> one nickel pulse; jam rises 64 cycles after stable goes high; jam clears 5 cycles after the sensor drops.
- Reset asserted during the cycle a deferred nickel is pending -> no nickel pulse after reset; busy=0; all outputs 0.
- With COIN_ACCEPTOR_TOTAL_EN: 3 nickels then 2 dimes, spaced 20 cycles apart -> total=35; assert clear_total -> total=0 on the next cycle.
